// File: rtl/seq_decoder.sv
// Registered N-to-2^N decoder with per-pattern dwell time: one-hot and thermometer
// patterns held for DWELL cycles, plus continuous and single-pass pointer scans.
module seq_decoder #(
   parameter int N     = 3,
   parameter int DWELL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              e,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [N-1:0]      a,
   output logic [2**N-1:0]   y,
   output logic              active,
   output logic              wrap,
   output logic [1:0]        dbg_state_o
);

   localparam int W   = 2**N;
   localparam int DCW = $clog2(DWELL + 1);
   localparam logic [DCW-1:0] DWELL_M1 = DCW'(DWELL - 1);
   localparam logic [N-1:0]   P_MAX    = {N{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_SCAN  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     m_q, m_d;
   logic [N-1:0]   p_q, p_d;
   logic [DCW-1:0] dc_q, dc_d;
   logic [W-1:0]   y_q, y_d;
   logic           active_q, active_d;
   logic           wrap_q, wrap_d;
   logic [N-1:0]   p_inc;

   // md=01 selects thermometer (bits [ptr:0]); anything else is one-hot.
   function automatic logic [W-1:0] decode(input logic [1:0] md, input logic [N-1:0] ptr);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W; i++) begin
         if (md == 2'b01) v[i] = (i <= int'(ptr));
         else             v[i] = (i == int'(ptr));
      end
      return v;
   endfunction

   assign p_inc = p_q + 1'b1;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      p_d     = p_q;
      dc_d    = dc_q;
      y_d     = '0;
      wrap_d  = 1'b0;
      if (!e) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  m_d     = mode;
                  p_d     = a;
                  dc_d    = DWELL_M1;
                  state_d = mode[1] ? S_SCAN : S_DRIVE;
                  y_d     = decode(mode, a);
               end
            end
            S_DRIVE: begin
               if (dc_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  dc_d = dc_q - 1'b1;
                  y_d  = decode(m_q, p_q);
               end
            end
            S_SCAN: begin
               if (dc_q != '0) begin
                  dc_d = dc_q - 1'b1;
                  y_d  = decode(2'b00, p_q);
               end else if (m_q[0] && p_q == P_MAX) begin
                  state_d = S_IDLE;
               end else begin
                  // Wrap is flagged alongside the pattern it produces (y=...01).
                  p_d    = p_inc;
                  dc_d   = DWELL_M1;
                  wrap_d = (p_q == P_MAX);
                  y_d    = decode(2'b00, p_inc);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         m_q      <= 2'b00;
         p_q      <= '0;
         dc_q     <= '0;
         y_q      <= '0;
         active_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         p_q      <= p_d;
         dc_q     <= dc_d;
         y_q      <= y_d;
         active_q <= active_d;
         wrap_q   <= wrap_d;
      end
   end

   assign y           = y_q;
   assign active      = active_q;
   assign wrap        = wrap_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/seq_decoder.md
# seq_decoder

Parametrised, registered N-to-2^N decoder. Generalises the combinational 3-to-8 decoder with select width, output hold time and four modes. The modes are one-hot, thermometer, continuous scan and single-pass scan. It drives row/segment selects and multiplexed strobes where each output line must be held for a fixed number of cycles or walked in sequence.

## Interface
Parameters:
- N, default 3: select width; output width is 2^N.
- DWELL, default 1: cycles each decoded pattern is held; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- e  input  1  enable; deassertion aborts any operation.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  2  00 one-hot, 01 thermometer, 10 continuous scan, 11 single-pass scan.
- a  input  N  select / scan start index.
- y  output  2^N  registered decoded output.
- active  output  1  high while in DRIVE or SCAN.
- wrap  output  1  one-cycle pulse when the scan pointer wraps from 2^N-1 to 0.

## Operation
- FSM states: IDLE, DRIVE, SCAN.
- Internal registers: latched mode m, pointer p (N bits), dwell counter dc (ceil(log2(DWELL+1)) bits).
- IDLE:
  - Outputs: y=0, active=0, wrap=0.
  - If start=1 and e=1 on an edge: latch m=mode and p=a, load dc=DWELL-1.
  - Next state is DRIVE for m=00/01 and SCAN for m=10/11.
- DRIVE:
  - m=00: y = 1<<p.
  - m=01: y has bits [p:0] set (p=0 gives 0…01; p=2^N-1 gives all ones).
  - dc decrements each cycle. When dc=0, return to IDLE on the next edge.
  - The total hold is exactly DWELL cycles.
- SCAN:
  - y = 1<<p.
  - When dc=0: reload dc=DWELL-1 and set p=p+1 mod 2^N.
  - m=10: runs until e=0. Assert wrap for the cycle in which p steps from 2^N-1 to 0; wrap is registered, so it is visible together with y=…01.
  - m=11: when dc=0 and p=2^N-1, go to IDLE instead of wrapping. wrap is never asserted in m=11.
- start, mode and a are ignored outside IDLE. A start while active does not restart.
- e=0 in any state: next edge forces IDLE, y=0, active=0, wrap=0.
- rst=1: asynchronously forces IDLE with y=0, active=0, wrap=0, p=0, dc=0. This holds mid-operation too. Nothing resumes after rst falls.
- No combinational path from inputs to outputs.

## Timing
- Latency: start sampled at edge k. The decoded y and active=1 appear after edge k, in cycle k+1.
- DRIVE occupies cycles k+1 … k+DWELL. The edge ending cycle k+DWELL returns to IDLE, so y=0 in cycle k+DWELL+1.
- A new start is accepted at the earliest in that IDLE cycle, k+DWELL+1. Back-to-back requests therefore have a minimum spacing of DWELL+1 cycles.
- SCAN: each pointer value is held exactly DWELL cycles.
  - A full period m=10 is 2^N·DWELL cycles.
  - m=11 starting at index a lasts (2^N−a)·DWELL cycles, followed by one IDLE cycle.
- Abort: e falling before edge j gives y=0 in cycle j+1 (the value sampled at edge j takes effect).
- DWELL=1: pattern changes every cycle; dc is constant 0.

## Test plan
(N=3, DWELL=2 unless stated.)
1. Reset mid-scan: start m=10, a=5, assert rst after 3 cycles. Require y=00h, active=0, wrap=0 immediately (asynchronous), and IDLE after release.
2. One-hot: start, m=00, a=6. Require y=40h for exactly 2 cycles beginning the cycle after start, then 00h. Require active high for those 2 cycles only.
3. Thermometer: a=0, then a=3, then a=7, each with its own start. Require y=01h, 0Fh, FFh respectively, each held 2 cycles.
4. Continuous scan: m=10, a=6, e held. Require sequence 40h,40h,80h,80h,01h,01h,02h… with wrap=1 only in the first 01h cycle. Deassert e and require y=00h one cycle later.
5. Single pass: m=11, a=5. Require 20h×2, 40h×2, 80h×2, then 00h with active=0 and wrap never asserted. A start with a=1 issued mid-pass must be ignored.
6. DWELL=1 and e low at start: start with e=0 must be ignored. Then m=10, a=7 with e=1 gives 80h,01h(wrap),02h on consecutive cycles.
